// File: rtl/bht_update_queue.sv
// rtl/bht_update_queue.sv - FIFO of resolved-branch updates drained into the shared BHT update port (optional BHT_UPDQ_BYPASS_EN)
module bht_update_queue #(
  parameter int VLEN       = 64,
  parameter int INDEX_BITS = 8,
  parameter int DEPTH      = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_bp_i,
  input  logic                       debug_mode_i,
  input  logic                       resolved_valid_i,
  input  logic [VLEN-1:0]            resolved_pc_i,
  input  logic                       resolved_taken_i,
  input  logic [INDEX_BITS-1:0]      resolved_index_i,
  input  logic                       port_busy_i,
  output logic                       bht_update_valid_o,
  output logic [VLEN-1:0]            bht_update_pc_o,
  output logic                       bht_update_taken_o,
  output logic [INDEX_BITS-1:0]      bht_update_index_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       dropped_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [VLEN-1:0]       pc_mem    [DEPTH];
  logic                  taken_mem [DEPTH];
  logic [INDEX_BITS-1:0] index_mem [DEPTH];

  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [CNT_W-1:0] count_q;
  logic             dropped_q;

  logic has_head;
  logic pop;
  logic push_req;
  logic room;
  logic byp;
  logic push;
  logic drop;

  assign has_head = (count_q != '0);
  // The BHT has no ready: presenting valid is the pop.
  assign pop      = has_head & ~port_busy_i & ~debug_mode_i & ~flush_bp_i;
  assign push_req = resolved_valid_i & ~debug_mode_i & ~flush_bp_i;
  // A full queue can still take an entry when the head leaves this cycle.
  assign room     = (count_q < DEPTH_C) | pop;

`ifdef BHT_UPDQ_BYPASS_EN
  // Empty queue and a free port: hand the update straight to the BHT.
  assign byp = ~has_head & push_req & ~port_busy_i;
`else
  assign byp = 1'b0;
`endif

  assign push = push_req & room & ~byp;
  assign drop = push_req & ~room;

  // Entry storage; contents are only visible while counted, so no reset needed.
  always_ff @(posedge clk_i) begin
    if (push) begin
      pc_mem[tail_q]    <= resolved_pc_i;
      taken_mem[tail_q] <= resolved_taken_i;
      index_mem[tail_q] <= resolved_index_i;
    end
  end

  // Pointers, occupancy and the registered drop pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      dropped_q <= 1'b0;
    end else begin
      dropped_q <= drop;
      if (flush_bp_i) begin
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
      end else begin
        if (push) tail_q <= tail_q + PTR_W'(1);
        if (pop)  head_q <= head_q + PTR_W'(1);
        if (push && !pop)      count_q <= count_q + CNT_W'(1);
        else if (pop && !push) count_q <= count_q - CNT_W'(1);
      end
    end
  end

  // Output mux: bypassed input, else head entry, else zeros when empty.
  always_comb begin
    bht_update_valid_o = pop | byp;
    bht_update_pc_o    = '0;
    bht_update_taken_o = 1'b0;
    bht_update_index_o = '0;
    if (byp) begin
      bht_update_pc_o    = resolved_pc_i;
      bht_update_taken_o = resolved_taken_i;
      bht_update_index_o = resolved_index_i;
    end else if (has_head) begin
      bht_update_pc_o    = pc_mem[head_q];
      bht_update_taken_o = taken_mem[head_q];
      bht_update_index_o = index_mem[head_q];
    end
  end

  assign count_o   = count_q;
  assign full_o    = (count_q == DEPTH_C);
  assign dropped_o = dropped_q;

endmodule

// File: tb/tb_bht_update_queue.sv
// tb/tb_bht_update_queue.sv - scoreboard bench for bht_update_queue
module tb_bht_update_queue;

  localparam int VLEN       = 64;
  localparam int INDEX_BITS = 8;
  localparam int DEPTH      = 4;
  localparam int CNT_W      = $clog2(DEPTH + 1);

`ifdef BHT_UPDQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic [VLEN-1:0]       pc;
    logic                  taken;
    logic [INDEX_BITS-1:0] idx;
  } upd_t;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  flush = 1'b0;
  logic                  dbg = 1'b0;
  logic                  rv = 1'b0;
  logic [VLEN-1:0]       rpc = '0;
  logic                  rtk = 1'b0;
  logic [INDEX_BITS-1:0] ridx = '0;
  logic                  busy = 1'b0;
  logic                  valid;
  logic [VLEN-1:0]       opc;
  logic                  otk;
  logic [INDEX_BITS-1:0] oidx;
  logic [CNT_W-1:0]      count;
  logic                  full;
  logic                  dropped;

  upd_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  bht_update_queue #(.VLEN(VLEN), .INDEX_BITS(INDEX_BITS), .DEPTH(DEPTH)) dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .flush_bp_i         (flush),
    .debug_mode_i       (dbg),
    .resolved_valid_i   (rv),
    .resolved_pc_i      (rpc),
    .resolved_taken_i   (rtk),
    .resolved_index_i   (ridx),
    .port_busy_i        (busy),
    .bht_update_valid_o (valid),
    .bht_update_pc_o    (opc),
    .bht_update_taken_o (otk),
    .bht_update_index_o (oidx),
    .count_o            (count),
    .full_o             (full),
    .dropped_o          (dropped)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Every presented update must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && valid) begin
      if (sb.size() == 0) begin
        check("unexpected_update", 64'(oidx), 64'hFFFF);
      end else begin
        upd_t e;
        e = sb.pop_front();
        check("sb_pc", opc, e.pc);
        check("sb_taken", 64'(otk), 64'(e.taken));
        check("sb_idx", 64'(oidx), 64'(e.idx));
      end
    end
  end

  // Drive one resolved update across one clock edge; exp_acc records it in the scoreboard.
  task automatic push(input logic [VLEN-1:0] pc, input logic tk, input logic [INDEX_BITS-1:0] idx,
                      input bit exp_acc);
    rv = 1'b1; rpc = pc; rtk = tk; ridx = idx;
    if (exp_acc) sb.push_back('{pc: pc, taken: tk, idx: idx});
    @(posedge clk); #1;
    rv = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(2);
    // Reset state
    check("rst_valid", 64'(valid), 0);
    check("rst_count", 64'(count), 0);
    check("rst_full", 64'(full), 0);
    check("rst_dropped", 64'(dropped), 0);
    check("rst_pc", opc, 0);
    rst_n = 1'b1;
    idle(1);

    // Single push
    rv = 1'b1; rpc = 64'h1000; rtk = 1'b1; ridx = 8'h10;
    sb.push_back('{pc: 64'h1000, taken: 1'b1, idx: 8'h10});
    #1 check("single_push_cycle_valid", 64'(valid), 64'(BYP));
    @(posedge clk); #1;
    rv = 1'b0;
    if (!BYP) begin
      check("single_next_valid", 64'(valid), 1);
      check("single_next_idx", 64'(oidx), 64'h10);
      check("single_next_pc", opc, 64'h1000);
      idle(1);
    end
    check("single_after_count", 64'(count), 0);
    check("single_after_valid", 64'(valid), 0);

    // Busy port: fill, then drop the fifth
    busy = 1'b1;
    for (int i = 1; i <= 4; i++) push(64'h2000 + 64'(i * 4), i[0], 8'(i), 1'b1);
    check("fill_dropped_none", 64'(dropped), 0);
    push(64'h2014, 1'b1, 8'd5, 1'b0);
    check("fill_count", 64'(count), 4);
    check("fill_full", 64'(full), 1);
    check("fill_dropped_pulse", 64'(dropped), 1);
    busy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1 check("drain_valid", 64'(valid), 1);
      @(posedge clk); #1;
      if (i == 0) check("drop_pulse_one_cycle", 64'(dropped), 0);
    end
    check("drain_count", 64'(count), 0);

    // Full queue with a simultaneous pop and push
    busy = 1'b1;
    for (int i = 1; i <= 4; i++) push(64'h3000 + 64'(i), 1'b0, 8'(8'h20 + i), 1'b1);
    busy = 1'b0;
    push(64'h3009, 1'b1, 8'd9, 1'b1);
    check("full_pushpop_count", 64'(count), 4);
    check("full_pushpop_dropped", 64'(dropped), 0);
    idle(4);
    check("full_pushpop_drained", 64'(count), 0);

    // Flush with a concurrent push
    busy = 1'b1;
    for (int i = 1; i <= 3; i++) push(64'h4000 + 64'(i), 1'b1, 8'(8'h30 + i), 1'b1);
    busy = 1'b0;
    flush = 1'b1;
    rv = 1'b1; rpc = 64'h403F; rtk = 1'b1; ridx = 8'h3F;
    sb.delete();
    #1 check("flush_valid", 64'(valid), 0);
    @(posedge clk); #1;
    rv = 1'b0; flush = 1'b0;
    check("flush_count", 64'(count), 0);
    check("flush_full", 64'(full), 0);
    idle(3);
    check("flush_stays_empty", 64'(count), 0);

    // Debug mode holds entries and ignores new ones
    busy = 1'b1;
    push(64'h5001, 1'b0, 8'h41, 1'b1);
    push(64'h5002, 1'b1, 8'h42, 1'b1);
    busy = 1'b0; dbg = 1'b1;
    rv = 1'b1; rpc = 64'h5003; rtk = 1'b0; ridx = 8'h43;
    #1 check("debug_valid", 64'(valid), 0);
    @(posedge clk); #1;
    rv = 1'b0;
    check("debug_count", 64'(count), 2);
    check("debug_dropped", 64'(dropped), 0);
    dbg = 1'b0;
    idle(2);
    check("debug_resume_count", 64'(count), 0);

    // Asynchronous reset mid-drain
    busy = 1'b1;
    for (int i = 1; i <= 3; i++) push(64'h6000 + 64'(i), 1'b1, 8'(8'h50 + i), 1'b1);
    busy = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("areset_valid", 64'(valid), 0);
    check("areset_count", 64'(count), 0);
    check("areset_idx", 64'(oidx), 0);
    check("areset_pc", opc, 0);
    idle(2);
    rst_n = 1'b1;
    idle(2);
    check("post_reset_count", 64'(count), 0);
    check("post_reset_valid", 64'(valid), 0);
    check("sb_empty_at_end", 64'(sb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
